// File: rtl/c5efa7_fpga_bup_qsys_enet_pll_rst_ctrl_if.sv
// Ethernet PLL reset controller: PLL-side and status signal bundle.
// master = controller, slave = PLL / system side.
interface c5efa7_fpga_bup_qsys_enet_pll_rst_ctrl_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       enet_reset_n;
  logic       lock_ok;
  logic       lock_fail;
  logic [3:0] retry_count;
  logic       lost_lock;

  modport master (
    input  pll_locked,
    input  force_relock,
    output pll_rst,
    output enet_reset_n,
    output lock_ok,
    output lock_fail,
    output retry_count,
    output lost_lock
  );

  modport slave (
    output pll_locked,
    output force_relock,
    input  pll_rst,
    input  enet_reset_n,
    input  lock_ok,
    input  lock_fail,
    input  retry_count,
    input  lost_lock
  );
endinterface

// File: rtl/c5efa7_fpga_bup_qsys_enet_pll_rst_ctrl.sv
// Ethernet PLL reset sequencer: pulses PLL reset, qualifies lock,
// releases the MAC/PHY reset, and re-arms with bounded retries.
module c5efa7_fpga_bup_qsys_enet_pll_rst_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 16
) (
  input logic refclk,
  input logic rst_n,
  c5efa7_fpga_bup_qsys_enet_pll_rst_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       retry_q, retry_n;
  logic             sync_q, lk_s;
  logic             lost_n;
  logic             pll_rst_q;
  logic             enet_q;
  logic             ok_q;
  logic             fail_q;
  logic             lost_q;

  always_comb begin
    state_n = state_q;
    retry_n = retry_q;
    lost_n  = 1'b0;
    cnt_n   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    if (bus.force_relock) begin
      state_n = RESET_PLL;
      retry_n = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_n = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_n = STABILIZE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q < MAX_R) begin
              retry_n = retry_q + 4'd1;
              state_n = RESET_PLL;
            end else begin
              state_n = FAIL;
            end
          end
        end
        STABILIZE: begin
          // a lock drop on the final count still wins
          if (!lk_s) begin
            state_n = WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_n = RUN;
            retry_n = '0;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_n = RESET_PLL;
            lost_n  = 1'b1;
          end
        end
        FAIL: ;
        default: state_n = RESET_PLL;
      endcase
    end
    if (bus.force_relock || (state_n != state_q)) cnt_n = '0;
  end

  // outputs registered off next state so they align with the state
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q    <= 1'b0;
      lk_s      <= 1'b0;
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      enet_q    <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      sync_q    <= bus.pll_locked;
      lk_s      <= sync_q;
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      retry_q   <= retry_n;
      pll_rst_q <= (state_n == RESET_PLL);
      enet_q    <= (state_n == RUN);
      ok_q      <= (state_n == RUN);
      fail_q    <= (state_n == FAIL);
      lost_q    <= lost_n;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.enet_reset_n = enet_q;
  assign bus.lock_ok      = ok_q;
  assign bus.lock_fail    = fail_q;
  assign bus.retry_count  = retry_q;
  assign bus.lost_lock    = lost_q;

endmodule
